// File: rtl/output_port_arbiter.sv
// Per-output-port arbiter: picks one requesting input channel (round-robin or
// fixed priority) and holds the grant until the packet's EOP beat is accepted
// or the optional watchdog expires.
module output_port_arbiter #(
  parameter int NUM_CH  = 5,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 0,
  parameter int IDX_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              eop,
  input  logic              ack,
  output logic [NUM_CH-1:0] gnt,
  output logic [NUM_CH-1:0] sel,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              idle,
  output logic              timeout_err
);

  // Counter sized to hold TIMEOUT; a 1-bit stub keeps the code legal when disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT_ACK} state_t;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] gnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  last_idx;
  logic [CNT_W-1:0]  cnt;
  logic              terr_reg;

  logic [IDX_W-1:0]  win_idx;
  logic              win_vld;
  logic              pkt_end;
  logic              wd_fire;

  // Winner selection; loops run from the lowest priority to the highest so the
  // last match assigned is the winner.
  always_comb begin
    int c;
    c       = 0;
    win_idx = '0;
    win_vld = 1'b0;
    if (RR_MODE != 0) begin
      for (int i = NUM_CH; i >= 1; i--) begin
        c = (int'(last_idx) + i) % NUM_CH;
        if (req[c]) begin
          win_idx = IDX_W'(c);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i]) begin
          win_idx = IDX_W'(i);
          win_vld = 1'b1;
        end
      end
    end
  end

  // Packet end and watchdog expiry; a normal end in the expiry cycle wins.
  always_comb begin
    pkt_end = ((state == S_XFER) && eop && ack) || ((state == S_WAIT_ACK) && ack);
    wd_fire = (TIMEOUT > 0) && (state != S_IDLE) &&
              (cnt == CNT_W'(TIMEOUT - 1)) && !pkt_end;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (win_vld) state_nxt = S_XFER;
      S_XFER:     if (eop && ack) state_nxt = S_IDLE;
                  else if (eop) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (ack) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (wd_fire) state_nxt = S_IDLE;
  end

  // State, grant capture, round-robin pointer and saturating watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt_reg  <= '0;
      idx_reg  <= '0;
      last_idx <= IDX_W'(NUM_CH - 1);
      cnt      <= '0;
      terr_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      terr_reg <= wd_fire;
      if ((state == S_IDLE) && win_vld) begin
        gnt_reg  <= {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
        idx_reg  <= win_idx;
        last_idx <= win_idx;
        cnt      <= '0;
      end else if ((state != S_IDLE) && (cnt != CNT_W'(TIMEOUT))) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Outputs are decoded from registered state and gated off while idle.
  always_comb begin
    idle        = (state == S_IDLE);
    gnt         = idle ? '0 : gnt_reg;
    sel         = gnt;
    grant_idx   = idle ? '0 : idx_reg;
    timeout_err = terr_reg;
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench: a round-robin instance with an 8-cycle watchdog and a
// fixed-priority instance without one, sharing stimulus.
module tb_output_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = '0;
  logic       eop = 1'b0;
  logic       ack = 1'b0;

  logic [4:0] rr_gnt, rr_sel, fp_gnt, fp_sel;
  logic [2:0] rr_idx, fp_idx;
  logic       rr_idle, fp_idle, rr_terr, fp_terr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  output_port_arbiter #(.NUM_CH(5), .RR_MODE(1), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .eop(eop), .ack(ack),
    .gnt(rr_gnt), .sel(rr_sel), .grant_idx(rr_idx), .idle(rr_idle),
    .timeout_err(rr_terr));

  output_port_arbiter #(.NUM_CH(5), .RR_MODE(0), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .eop(eop), .ack(ack),
    .gnt(fp_gnt), .sel(fp_sel), .grant_idx(fp_idx), .idle(fp_idle),
    .timeout_err(fp_terr));

  typedef struct {
    logic       fp;
    logic       rst;
    logic [4:0] req;
    logic       eop;
    logic       ack;
    logic [4:0] gnt;
    logic [2:0] idx;
    logic       idle;
    logic       terr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic fp, logic r, logic [4:0] q, logic e, logic a,
                              logic [4:0] g, logic [2:0] i, logic id, logic te);
    vec_t v;
    v.fp = fp; v.rst = r; v.req = q; v.eop = e; v.ack = a;
    v.gnt = g; v.idx = i; v.idle = id; v.terr = te;
    return v;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, k, act, exp);
    end
  endtask

  // Round-robin packet: grant cycle, one plain beat, then eop&ack beat.
  task automatic rr_pkt(logic [4:0] q, logic [4:0] g, logic [2:0] i);
    tv.push_back(mk(0, 0, q, 0, 1, g, i, 0, 0));
    tv.push_back(mk(0, 0, q, 0, 1, g, i, 0, 0));
    tv.push_back(mk(0, 0, q, 1, 1, 5'b0, 3'd0, 1, 0));
  endtask

  initial begin
    // Reset with all requests, then first grant from pointer NUM_CH-1.
    for (int k = 0; k < 3; k++) tv.push_back(mk(0, 1, 5'b11111, 0, 0, 5'b0, 3'd0, 1, 0));
    tv.push_back(mk(0, 0, 5'b00100, 0, 0, 5'b00100, 3'd2, 0, 0));
    tv.push_back(mk(0, 0, 5'b00000, 1, 1, 5'b00000, 3'd0, 1, 0));
    // Round-robin fairness from a fresh pointer: 0,2,4,0,2 with one-cycle bubbles.
    for (int k = 0; k < 2; k++) tv.push_back(mk(0, 1, 5'b10101, 0, 1, 5'b0, 3'd0, 1, 0));
    rr_pkt(5'b10101, 5'b00001, 3'd0);
    rr_pkt(5'b10101, 5'b00100, 3'd2);
    rr_pkt(5'b10101, 5'b10000, 3'd4);
    rr_pkt(5'b10101, 5'b00001, 3'd0);
    rr_pkt(5'b10101, 5'b00100, 3'd2);
    // Late ack: eop without ack parks in S_WAIT_ACK; eop is ignored there.
    tv.push_back(mk(0, 0, 5'b01000, 0, 0, 5'b01000, 3'd3, 0, 0));
    for (int k = 0; k < 3; k++) tv.push_back(mk(0, 0, 5'b00000, 1, 0, 5'b01000, 3'd3, 0, 0));
    tv.push_back(mk(0, 0, 5'b00000, 0, 1, 5'b00000, 3'd0, 1, 0));
    // Watchdog: grant held 8 cycles, released with one error pulse, then RR moves on.
    tv.push_back(mk(0, 0, 5'b01000, 0, 0, 5'b01000, 3'd3, 0, 0));
    for (int k = 0; k < 7; k++) tv.push_back(mk(0, 0, 5'b01001, 0, 0, 5'b01000, 3'd3, 0, 0));
    tv.push_back(mk(0, 0, 5'b01001, 0, 0, 5'b00000, 3'd0, 1, 1));
    tv.push_back(mk(0, 0, 5'b01001, 0, 0, 5'b00001, 3'd0, 0, 0));
    // Packet ends on the 8th grant cycle: normal end wins, no pulse.
    for (int k = 0; k < 7; k++) tv.push_back(mk(0, 0, 5'b00000, 0, 0, 5'b00001, 3'd0, 0, 0));
    tv.push_back(mk(0, 0, 5'b00000, 1, 1, 5'b00000, 3'd0, 1, 0));
    tv.push_back(mk(0, 0, 5'b00000, 0, 0, 5'b00000, 3'd0, 1, 0));
    // Reset mid-packet on beat 3; pointer must return to NUM_CH-1 (last was 0).
    tv.push_back(mk(0, 0, 5'b00001, 0, 0, 5'b00001, 3'd0, 0, 0));
    tv.push_back(mk(0, 0, 5'b00000, 0, 1, 5'b00001, 3'd0, 0, 0));
    tv.push_back(mk(0, 0, 5'b00000, 0, 1, 5'b00001, 3'd0, 0, 0));
    tv.push_back(mk(0, 1, 5'b00000, 0, 1, 5'b00000, 3'd0, 1, 0));
    tv.push_back(mk(0, 0, 5'b00011, 0, 0, 5'b00001, 3'd0, 0, 0));
    // Fixed priority: channel 1 always beats channel 4.
    for (int k = 0; k < 2; k++) tv.push_back(mk(1, 1, 5'b10110, 0, 0, 5'b0, 3'd0, 1, 0));
    for (int k = 0; k < 3; k++) begin
      tv.push_back(mk(1, 0, 5'b10110, 0, 0, 5'b00010, 3'd1, 0, 0));
      tv.push_back(mk(1, 0, 5'b10110, 1, 1, 5'b00000, 3'd0, 1, 0));
    end
    tv.push_back(mk(1, 0, 5'b10100, 0, 0, 5'b00100, 3'd2, 0, 0));
    tv.push_back(mk(1, 0, 5'b00000, 1, 1, 5'b00000, 3'd0, 1, 0));

    foreach (tv[k]) begin
      rst = tv[k].rst; req = tv[k].req; eop = tv[k].eop; ack = tv[k].ack;
      @(posedge clk); #1;
      if (tv[k].fp) begin
        chk("fp_gnt", k, 32'(fp_gnt), 32'(tv[k].gnt));
        chk("fp_sel", k, 32'(fp_sel), 32'(tv[k].gnt));
        chk("fp_idx", k, 32'(fp_idx), 32'(tv[k].idx));
        chk("fp_idle", k, 32'(fp_idle), 32'(tv[k].idle));
        chk("fp_terr", k, 32'(fp_terr), 32'(tv[k].terr));
      end else begin
        chk("rr_gnt", k, 32'(rr_gnt), 32'(tv[k].gnt));
        chk("rr_sel", k, 32'(rr_sel), 32'(tv[k].gnt));
        chk("rr_idx", k, 32'(rr_idx), 32'(tv[k].idx));
        chk("rr_idle", k, 32'(rr_idle), 32'(tv[k].idle));
        chk("rr_terr", k, 32'(rr_terr), 32'(tv[k].terr));
      end
    end

    // Watchdog disabled: a grant with no end holds indefinitely, dropping req is ignored.
    rst = 1'b1; req = '0; eop = 0; ack = 0;
    @(posedge clk); #1;
    rst = 1'b0; req = 5'b01000;
    @(posedge clk); #1;
    req = 5'b00000;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("fp_hold_gnt", k, 32'(fp_gnt), 32'h08);
      chk("fp_hold_terr", k, 32'(fp_terr), 32'h0);
      chk("fp_onehot", k, 32'($onehot0(fp_gnt)), 32'h1);
    end
    eop = 1'b1; ack = 1'b1;
    begin
      int waited;
      waited = 0;
      @(posedge clk); #1;
      eop = 1'b0; ack = 1'b0;
      while (!fp_idle && waited < 5) begin
        @(posedge clk); #1;
        waited++;
      end
      chk("fp_release_wait", 0, 32'(waited), 32'h0);
      chk("fp_release_gnt", 0, 32'(fp_gnt), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
